// File: rtl/sram_rr_pkg.sv
// sram_rr_pkg: shared types and constants for sram_rr_ctrl (FSM states, requester id, default widths, arbiter reset state)
package sram_rr_pkg;
  localparam int N_REQ = 2;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
  typedef logic req_id_t;
  localparam req_id_t RESET_LAST_GNT = 1'b1;
endpackage

// File: rtl/sram_rr_ctrl_if.sv
// sram_rr_ctrl_if: two valid/ready request channels, two read-response channels and the SRAM pins; slave = controller side, master = clients plus SRAM side
interface sram_rr_ctrl_if import sram_rr_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
  logic req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic mem_we;
  modport slave (
    input req0_valid, req0_we, req0_addr, req0_wdata, req1_valid, req1_we, req1_addr, req1_wdata, mem_data_out,
    output req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata, mem_addr, mem_data_in, mem_we
  );
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req1_valid, req1_we, req1_addr, req1_wdata, mem_data_out,
    input req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata, mem_addr, mem_data_in, mem_we
  );
endinterface

// File: rtl/sram_rr_ctrl_arb.sv
// rr_arb2: combinational two-way round-robin arbiter; ports valid[1:0], last_gnt in, one-hot grant out (ties go to the requester not granted last)
module rr_arb2 import sram_rr_pkg::*; (
  input  logic [N_REQ-1:0] valid,
  input  req_id_t          last_gnt,
  output logic [N_REQ-1:0] grant
);
  assign grant[0] = valid[0] && (!valid[1] || last_gnt);
  assign grant[1] = valid[1] && (!valid[0] || !last_gnt);
endmodule

// File: rtl/sram_rr_ctrl.sv
// sram_rr_ctrl: round-robin two-requester controller for a single-port registered-read SRAM; ports clk, rst (sync active-high), bus (slave: req/rsp channels and mem pins); define SRAM_RR_WR_ACK_EN to get a response pulse for writes
module sram_rr_ctrl import sram_rr_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic rst,
  sram_rr_ctrl_if.slave bus
);
`ifdef SRAM_RR_WR_ACK_EN
  localparam state_t WR_NEXT = RESP;
`else
  localparam state_t WR_NEXT = IDLE;
`endif
  state_t state, state_n;
  req_id_t last_gnt, op_id, gnt_id;
  logic op_we, acc, sel_we, mem_we;
  logic [N_REQ-1:0] grant;
  logic [ADDR_W-1:0] mem_addr, sel_addr;
  logic [DATA_W-1:0] mem_data_in, sel_wdata, rdata0, rdata1;
  rr_arb2 u_arb (
    .valid({bus.req1_valid, bus.req0_valid}),
    .last_gnt(last_gnt),
    .grant(grant)
  );
  assign bus.req0_ready = (state == IDLE) && !rst && grant[0];
  assign bus.req1_ready = (state == IDLE) && !rst && grant[1];
  assign acc = bus.req0_ready || bus.req1_ready;
  assign gnt_id = grant[1];
  assign sel_we = gnt_id ? bus.req1_we : bus.req0_we;
  assign sel_addr = gnt_id ? bus.req1_addr : bus.req0_addr;
  assign sel_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;
  assign bus.rsp0_valid = (state == RESP) && !op_id;
  assign bus.rsp1_valid = (state == RESP) && op_id;
  assign bus.rsp0_rdata = rdata0;
  assign bus.rsp1_rdata = rdata1;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_data_in = mem_data_in;
  assign bus.mem_we = mem_we;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = acc ? ISSUE : IDLE;
      ISSUE:   state_n = op_we ? WR_NEXT : CAPT;
      CAPT:    state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= RESET_LAST_GNT;
      op_id <= '0;
      op_we <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_data_in <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      mem_we <= acc && sel_we;
      if (acc) begin
        last_gnt <= gnt_id;
        op_id <= gnt_id;
        op_we <= sel_we;
        mem_addr <= sel_addr;
        mem_data_in <= sel_wdata;
      end
      if (state == CAPT && !op_id) rdata0 <= bus.mem_data_out;
      if (state == CAPT && op_id) rdata1 <= bus.mem_data_out;
    end
  end
endmodule
